mem_port_arbiter: RTL

- Shares one single-port, fixed-latency unified memory between instruction fetch (IF) and the data-memory stage (DM).
- Contains a small FSM that serialises accesses and generates byte enables from the control unit's `datasize` code.
- Returns lane-aligned read data and drives the pipeline stall.
- Sits between the IF/MEM pipeline stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and
// the data-memory stage. Serialises accesses, builds byte enables and
// replicated store data, and returns lane-aligned load data.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_DM_RUN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic              dm_err,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int RUN_W = $clog2(MAX_DM_RUN + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic [RUN_W-1:0] dm_run;
    logic             cur_dm;
    logic             cur_we;
    logic [1:0]       cur_size;
    logic [1:0]       cur_off;

    logic             dm_mis;
    logic [3:0]       dm_be;
    logic [31:0]      dm_wrep;
    logic [31:0]      load_data;
    logic             run_full;
    logic             pick_dm;
    logic             unused_if_addr;

    assign stall          = (if_req & ~if_gnt) | (dm_req & ~dm_done);
    assign run_full       = (dm_run == RUN_W'(MAX_DM_RUN));
    // DM has priority unless IF has been starved for MAX_DM_RUN grants
    assign pick_dm        = dm_req & ~(if_req & run_full);
    assign unused_if_addr = ^if_addr[1:0];

    // Decode alignment, byte enables and lane-replicated store data of the DM request
    always_comb begin
        dm_mis  = 1'b0;
        dm_be   = 4'b1111;
        dm_wrep = dm_wdata;
        case (dm_size)
            2'b00: begin
                dm_be   = 4'b0001 << dm_addr[1:0];
                dm_wrep = {4{dm_wdata[7:0]}};
            end
            2'b01: begin
                dm_mis  = dm_addr[0];
                dm_be   = dm_addr[1] ? 4'b1100 : 4'b0011;
                dm_wrep = {2{dm_wdata[15:0]}};
            end
            default: dm_mis = |dm_addr[1:0];
        endcase
    end

    // Shift the returned word down to lane 0 and zero-fill above the access size
    always_comb begin
        load_data = mem_rdata;
        case (cur_size)
            2'b00: begin
                case (cur_off)
                    2'b00:   load_data = {24'h0, mem_rdata[7:0]};
                    2'b01:   load_data = {24'h0, mem_rdata[15:8]};
                    2'b10:   load_data = {24'h0, mem_rdata[23:16]};
                    default: load_data = {24'h0, mem_rdata[31:24]};
                endcase
            end
            2'b01:   load_data = {16'h0, cur_off[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // Access sequencer: select, issue, wait out the memory latency, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            dm_run    <= '0;
            cur_dm    <= 1'b0;
            cur_we    <= 1'b0;
            cur_size  <= 2'b00;
            cur_off   <= 2'b00;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_gnt    <= 1'b0;
            if_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            // Strobes and pulses default low; they are raised for exactly one cycle
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if_gnt  <= 1'b0;
            dm_done <= 1'b0;
            dm_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_dm) begin
                        if (!if_req) begin
                            dm_run <= '0;
                        end else if (!run_full) begin
                            dm_run <= dm_run + 1'b1;
                        end
                        if (dm_mis) begin
                            // Rejected without touching memory
                            dm_done  <= 1'b1;
                            dm_err   <= 1'b1;
                            dm_rdata <= '0;
                            state    <= RESP;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= dm_we;
                            mem_be    <= dm_be;
                            mem_addr  <= {dm_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= dm_wrep;
                            cur_dm    <= 1'b1;
                            cur_we    <= dm_we;
                            cur_size  <= dm_size;
                            cur_off   <= dm_addr[1:0];
                            state     <= ISSUE;
                        end
                    end else if (if_req) begin
                        dm_run    <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b1111;
                        mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= '0;
                        cur_dm    <= 1'b0;
                        cur_we    <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_we) begin
                        dm_done <= 1'b1;
                        state   <= RESP;
                    end else begin
                        lat_cnt <= CNT_W'(MEM_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (cur_dm) begin
                            dm_rdata <= load_data;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_gnt   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
